// File: rtl/trap_ctrl.sv
// Trap controller: edge-latched interrupt sources, mask, fixed priority and a periodic timer,
// presenting one trap at a time to the core. Define TRAP_CTRL_OVERRUN_EN to build the lost-interrupt counter.
module trap_ctrl #(
  parameter int unsigned        TIMER_W     = 16,
  parameter logic [TIMER_W-1:0] TIMER_RESET = '0,
  parameter logic [3:0]         MASK_RESET  = 4'b1111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               uart_irq,
  input  logic [1:0]         ext_irq,
  input  logic               page_fault,
  input  logic               deassert,
  input  logic               mask_wr,
  input  logic [3:0]         mask_in,
  input  logic               timer_wr,
  input  logic [TIMER_W-1:0] timer_in,
  output logic               irq,
  output logic               fault,
  output logic [3:0]         trapnr,
  output logic [3:0]         pending,
  output logic [7:0]         overrun
);

  typedef enum logic [1:0] {IDLE, PRESENT, FAULT, DRAIN} state_t;

  state_t             state;
  logic [3:0]         mask;
  logic [TIMER_W-1:0] reload;
  logic [TIMER_W-1:0] counter;
  logic               tick;
  logic               uart_q;
  logic [1:0]         ext_q;

  logic [3:0]         set_vec;
  logic [3:0]         clr_vec;
  logic [3:0]         eff;
  logic [3:0]         win_nr;
  logic               clear_en;

  // Pending bits are {ext1, ext0, timer, uart}; a set in the same cycle as a clear wins.
  always_comb begin
    set_vec  = {ext_irq[1] & ~ext_q[1], ext_irq[0] & ~ext_q[0], tick, uart_irq & ~uart_q};
    clear_en = (state == PRESENT) && deassert && !page_fault;
    clr_vec  = 4'b0000;
    if (clear_en) begin
      case (trapnr)
        4'd2:    clr_vec = 4'b0001;
        4'd3:    clr_vec = 4'b0010;
        4'd4:    clr_vec = 4'b0100;
        4'd5:    clr_vec = 4'b1000;
        default: clr_vec = 4'b0000;
      endcase
    end
    eff = pending & mask;
    if (eff[3])      win_nr = 4'd5;
    else if (eff[2]) win_nr = 4'd4;
    else if (eff[1]) win_nr = 4'd3;
    else if (eff[0]) win_nr = 4'd2;
    else             win_nr = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      irq     <= 1'b0;
      fault   <= 1'b0;
      trapnr  <= 4'd0;
      pending <= 4'b0000;
      mask    <= MASK_RESET;
      reload  <= TIMER_RESET;
      counter <= TIMER_RESET;
      tick    <= 1'b0;
      uart_q  <= 1'b0;
      ext_q   <= 2'b00;
    end else begin
      uart_q  <= uart_irq;
      ext_q   <= ext_irq;
      pending <= (pending & ~clr_vec) | set_vec;
      if (mask_wr)
        mask <= mask_in;

      // The tick is registered, so the timer pending bit lands one cycle after the reload.
      if (timer_wr) begin
        reload  <= timer_in;
        counter <= timer_in;
        tick    <= 1'b0;
      end else if (reload != '0) begin
        if (counter <= TIMER_W'(1)) begin
          counter <= reload;
          tick    <= 1'b1;
        end else begin
          counter <= counter - TIMER_W'(1);
          tick    <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (page_fault) begin
            fault  <= 1'b1;
            trapnr <= 4'd1;
            state  <= FAULT;
          end else if (|eff) begin
            irq    <= 1'b1;
            trapnr <= win_nr;
            state  <= PRESENT;
          end
        end
        PRESENT: begin
          if (page_fault) begin
            irq    <= 1'b0;
            fault  <= 1'b1;
            trapnr <= 4'd1;
            state  <= FAULT;
          end else if (deassert) begin
            irq    <= 1'b0;
            trapnr <= 4'd0;
            state  <= DRAIN;
          end
        end
        FAULT: begin
          if (deassert) begin
            fault  <= 1'b0;
            trapnr <= 4'd0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (!deassert)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TRAP_CTRL_OVERRUN_EN
  logic [3:0] ovr_hits;
  logic [2:0] ovr_cnt;
  logic [8:0] ovr_sum;

  // Each source that re-fires while still pending counts as one lost interrupt.
  always_comb begin
    ovr_hits = set_vec & pending & ~clr_vec;
    ovr_cnt  = 3'(ovr_hits[0]) + 3'(ovr_hits[1]) + 3'(ovr_hits[2]) + 3'(ovr_hits[3]);
    ovr_sum  = {1'b0, overrun} + 9'(ovr_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset)
      overrun <= 8'd0;
    else
      overrun <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
  end
`else
  assign overrun = 8'd0;
`endif

endmodule
